// File: rtl/pr_stage_pkg.sv
// Shared widths, control-field layout and bubble constant for pipeline-register stages.
package pr_stage_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CTRL_W_DEF = 4;
  localparam int RW_W_DEF   = 5;
  localparam int CNT_W_DEF  = 16;

  // Control field layout: wd_sel in [1:0], register-file write enable, data-memory write enable.
  localparam int CTRL_WD_SEL_LSB = 0;
  localparam int CTRL_WD_SEL_MSB = 1;
  localparam int CTRL_RF_WE      = 2;
  localparam int CTRL_DRAM_WE    = 3;

  // A bubble carries no write enables and no write-back select.
  localparam logic [CTRL_W_DEF-1:0] CTRL_BUBBLE = '0;

endpackage

// File: rtl/pr_stage_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  // Count up on inc, stick at all-ones, zero on clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pr_stage.sv
// Pipeline-register stage with flush/stall control and stall/bubble performance counters.
// Instantiated once per pipeline boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) with boundary-specific widths.
module pr_stage
  import pr_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int RW_W   = RW_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [RW_W-1:0]   wR_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              cnt_clr_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [RW_W-1:0]   wR_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  localparam logic [CTRL_W-1:0] BUBBLE = CTRL_W'(CTRL_BUBBLE);

  logic stall_inc;
  logic flush_inc;

  // A flush overrides a simultaneous stall, so that edge counts only as a bubble.
  assign stall_inc = stall_i & ~flush_i;
  assign flush_inc = flush_i;

  // Valid/control: flush forces a bubble, stall holds, otherwise load; control is
  // zeroed whenever the stage is not valid so a bubble can never write downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o <= 1'b0;
      ctrl_o  <= BUBBLE;
    end else if (flush_i) begin
      valid_o <= 1'b0;
      ctrl_o  <= BUBBLE;
    end else if (!stall_i) begin
      valid_o <= valid_i;
      ctrl_o  <= valid_i ? ctrl_i : BUBBLE;
    end
  end

  // Payload: only a plain load moves it; flush and stall both leave it in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wR_o   <= '0;
      data_o <= '0;
    end else if (!flush_i && !stall_i) begin
      wR_o   <= wR_i;
      data_o <= data_i;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .clr   (cnt_clr_i),
    .cnt   (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc),
    .clr   (cnt_clr_i),
    .cnt   (flush_cnt_o)
  );

endmodule

// File: tb/tb_pr_stage.sv
// Self-checking bench for pr_stage: directed vector table, corner sequences, random vs. model.
module tb_pr_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Default-width instance
  logic        stall_i = 0, flush_i = 0, valid_i = 0, cnt_clr_i = 0;
  logic [3:0]  ctrl_i = 0;
  logic [4:0]  wR_i = 0;
  logic [31:0] data_i = 0;
  logic        valid_o;
  logic [3:0]  ctrl_o;
  logic [4:0]  wR_o;
  logic [31:0] data_o;
  logic [15:0] stall_cnt_o, flush_cnt_o;

  pr_stage dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
    .ctrl_i(ctrl_i), .wR_i(wR_i), .data_i(data_i), .cnt_clr_i(cnt_clr_i),
    .valid_o(valid_o), .ctrl_o(ctrl_o), .wR_o(wR_o), .data_o(data_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  // Narrow instance for counter saturation
  logic        stall4 = 0, clr4 = 0, zero1 = 0;
  logic [3:0]  zero_ctrl = 0;
  logic [2:0]  zero_wr = 0;
  logic [7:0]  zero_data = 0;
  logic        valid4;
  logic [3:0]  ctrl4, sc4, fc4;
  logic [2:0]  wr4;
  logic [7:0]  data4;

  pr_stage #(.DATA_W(8), .CTRL_W(4), .RW_W(3), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .stall_i(stall4), .flush_i(zero1), .valid_i(zero1),
    .ctrl_i(zero_ctrl), .wR_i(zero_wr), .data_i(zero_data), .cnt_clr_i(clr4),
    .valid_o(valid4), .ctrl_o(ctrl4), .wR_o(wr4), .data_o(data4),
    .stall_cnt_o(sc4), .flush_cnt_o(fc4)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic v, input logic [3:0] c, input logic [4:0] w,
                         input logic [31:0] d, input logic [15:0] sc, input logic [15:0] fc);
    chk({tag, ".valid"}, 64'(valid_o), 64'(v));
    chk({tag, ".ctrl"},  64'(ctrl_o),  64'(c));
    chk({tag, ".wR"},    64'(wR_o),    64'(w));
    chk({tag, ".data"},  64'(data_o),  64'(d));
    chk({tag, ".stall_cnt"}, 64'(stall_cnt_o), 64'(sc));
    chk({tag, ".flush_cnt"}, 64'(flush_cnt_o), 64'(fc));
  endtask

  typedef struct {
    logic flush, stall, valid, clr;
    logic [3:0]  ctrl;
    logic [4:0]  wr;
    logic [31:0] data;
    logic        e_valid;
    logic [3:0]  e_ctrl;
    logic [4:0]  e_wr;
    logic [31:0] e_data;
    logic [15:0] e_sc, e_fc;
  } vec_t;

  vec_t vecs[9];

  // reference model state
  logic        m_valid;
  logic [3:0]  m_ctrl;
  logic [4:0]  m_wr;
  logic [31:0] m_data;
  int          m_sc, m_fc;

  initial begin
    //          flush stall valid clr ctrl  wr  data           ev ec  ew  ed             sc fc
    vecs[0] = '{0, 0, 1, 0, 4'h6, 5, 32'hDEADBEEF, 1, 4'h6, 5, 32'hDEADBEEF, 0, 0};
    vecs[1] = '{0, 0, 1, 0, 4'h1, 1, 32'h1,        1, 4'h1, 1, 32'h1,        0, 0};
    vecs[2] = '{0, 1, 1, 0, 4'h2, 9, 32'hAAAA,     1, 4'h1, 1, 32'h1,        1, 0};
    vecs[3] = '{0, 1, 1, 0, 4'h3, 9, 32'hBBBB,     1, 4'h1, 1, 32'h1,        2, 0};
    vecs[4] = '{0, 1, 0, 0, 4'h4, 9, 32'hCCCC,     1, 4'h1, 1, 32'h1,        3, 0};
    vecs[5] = '{1, 1, 1, 0, 4'hF, 8, 32'hDDDD,     0, 4'h0, 1, 32'h1,        3, 1};
    vecs[6] = '{0, 0, 0, 0, 4'hF, 7, 32'h77,       0, 4'h0, 7, 32'h77,       3, 1};
    vecs[7] = '{0, 0, 1, 1, 4'h4, 2, 32'h22,       1, 4'h4, 2, 32'h22,       0, 0};
    vecs[8] = '{1, 0, 1, 0, 4'h8, 3, 32'h33,       0, 4'h0, 2, 32'h22,       0, 1};

    // Reset state while rst_n is held low
    #12;
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    chk("reset.sc4", 64'(sc4), 64'(0));

    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      flush_i = vecs[i].flush; stall_i = vecs[i].stall; valid_i = vecs[i].valid;
      cnt_clr_i = vecs[i].clr; ctrl_i = vecs[i].ctrl; wR_i = vecs[i].wr; data_i = vecs[i].data;
      @(posedge clk); #1;
      chk_all($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_ctrl, vecs[i].e_wr,
              vecs[i].e_data, vecs[i].e_sc, vecs[i].e_fc);
    end

    // Saturation on the 4-bit counter instance, then clear beats stall
    @(negedge clk);
    flush_i = 0; stall_i = 0; valid_i = 0; cnt_clr_i = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      stall4 = 1;
      @(posedge clk); #1;
      chk($sformatf("sat4.cyc%0d", i), 64'(sc4), 64'((i + 1 < 15) ? i + 1 : 15));
    end
    @(negedge clk);
    clr4 = 1; stall4 = 1;
    @(posedge clk); #1;
    chk("sat4.clr_vs_stall", 64'(sc4), 64'(0));
    chk("sat4.flush_cnt", 64'(fc4), 64'(0));
    @(negedge clk);
    clr4 = 0; stall4 = 0;

    // Asynchronous reset in the middle of a stall
    @(negedge clk);
    valid_i = 1; ctrl_i = 4'h5; wR_i = 4; data_i = 32'h55;
    @(posedge clk); #1;
    @(negedge clk);
    stall_i = 1; data_i = 32'h66;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1; stall_i = 0; flush_i = 0; valid_i = 0; ctrl_i = 0; wR_i = 0; data_i = 0;
    @(posedge clk); #1;
    chk_all("post_rst", 0, 0, 0, 0, 0, 0);

    // Random stimulus against the behavioural model
    m_valid = 0; m_ctrl = 0; m_wr = 0; m_data = 0; m_sc = 0; m_fc = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      flush_i   = ($urandom_range(7) == 0);
      stall_i   = ($urandom_range(3) == 0);
      valid_i   = $urandom_range(1);
      cnt_clr_i = ($urandom_range(31) == 0);
      ctrl_i    = 4'($urandom);
      wR_i      = 5'($urandom);
      data_i    = $urandom;
      // Counters: clear wins, otherwise count and stop at the top
      if (cnt_clr_i) begin
        m_sc = 0; m_fc = 0;
      end else begin
        if (stall_i && !flush_i) m_sc = (m_sc + 1 > 65535) ? 65535 : m_sc + 1;
        if (flush_i)             m_fc = (m_fc + 1 > 65535) ? 65535 : m_fc + 1;
      end
      if (flush_i) begin
        m_valid = 0; m_ctrl = 0;
      end else if (!stall_i) begin
        m_valid = valid_i;
        m_ctrl  = valid_i ? ctrl_i : 4'h0;
        m_wr    = wR_i;
        m_data  = data_i;
      end
      @(posedge clk); #1;
      chk_all($sformatf("rnd%0d", i), m_valid, m_ctrl, m_wr, m_data, 16'(m_sc), 16'(m_fc));
      chk($sformatf("rnd%0d.bubble_ctrl", i), 64'(!valid_o && ctrl_o != 0), 64'(0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pr_stage.md
PR_STAGE -- requirements
Module: pr_stage

Interface
REQ-001 Parameter DATA_W, default 32: payload width in bits, covering ALU result, rd2 and write-back data.
REQ-002 Parameter CTRL_W, default 4: control field width, covering wd_sel, rf_we and dram_we.
REQ-003 Parameter RW_W, default 5: destination register index width.
REQ-004 Parameter CNT_W, default 16: width of each performance counter.
REQ-005 clk  input  1  the block's single clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  reset, asynchronous and active-low.
REQ-007 stall_i  input  1  hold the current stage contents.
REQ-008 flush_i  input  1  insert a bubble.
REQ-009 valid_i  input  1  upstream instruction is valid.
REQ-010 ctrl_i  input  CTRL_W  upstream control bits.
REQ-011 wR_i  input  RW_W  upstream destination register.
REQ-012 data_i  input  DATA_W  upstream payload.
REQ-013 cnt_clr_i  input  1  synchronous clear of both counters.
REQ-014 valid_o  output  1  stage holds a valid instruction.
REQ-015 ctrl_o  output  CTRL_W  registered control bits.
REQ-016 wR_o  output  RW_W  registered destination register.
REQ-017 data_o  output  DATA_W  registered payload.
REQ-018 stall_cnt_o  output  CNT_W  number of stalled cycles.
REQ-019 flush_cnt_o  output  CNT_W  number of bubbles inserted.

Function
REQ-020 The stage SHALL apply a per-edge priority of flush, then stall, then load.
REQ-021 On flush_i=1 the stage SHALL set valid_o=0 and ctrl_o=0, and SHALL hold wR_o and data_o, regardless of stall_i.
REQ-022 On stall_i=1 with flush_i=0 the stage SHALL hold all of valid_o, ctrl_o, wR_o and data_o.
REQ-023 On load with valid_i=1, valid_o, ctrl_o, wR_o and data_o SHALL take valid_i, ctrl_i, wR_i and data_i one cycle later (latency 1).
REQ-024 On load with valid_i=0 the stage SHALL set valid_o=0 and ctrl_o=0, and SHALL still load wR_o and data_o.
REQ-025 ctrl_o SHALL be nonzero only while valid_o=1, so that a bubble can never assert rf_we or dram_we downstream.
REQ-026 stall_cnt_o SHALL increment by 1 on every edge with stall_i=1 and flush_i=0.
REQ-027 flush_cnt_o SHALL increment by 1 on every edge with flush_i=1.
REQ-028 Both counters SHALL saturate at 2^CNT_W-1 and SHALL not wrap.
REQ-029 cnt_clr_i=1 SHALL zero both counters on the next edge, taking priority over any increment in the same cycle.
REQ-030 cnt_clr_i SHALL not affect valid_o, ctrl_o, wR_o or data_o.
REQ-031 All outputs SHALL be driven directly from flops, with no combinational path from any input to any output.

Reset
REQ-032 While rst_n=0 the block SHALL force valid_o=0, ctrl_o=0, wR_o=0, data_o=0, stall_cnt_o=0 and flush_cnt_o=0, asynchronously.
REQ-033 On the first rising edge after rst_n deasserts, the block SHALL apply REQ-020 normally.
REQ-034 Reset asserted mid-stall or mid-flush SHALL discard that state, and no stall or flush SHALL persist across reset.

Structure
REQ-035 A shared package SHALL hold the default widths and the CTRL bit positions: WD_SEL [1:0], RF_WE [2], DRAM_WE [3].
REQ-036 The shared package SHALL also hold the all-zero bubble control constant.
REQ-037 The two counters SHALL each be an instance of one sub-module, sat_counter (parameter W; ports inc, clr; saturating output).
REQ-038 Multiple pipeline boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB) SHALL be built as instances of pr_stage with differing widths.

Verification
REQ-039 Reset release, then valid_i=1, ctrl_i=4'b0110, wR_i=5, data_i=32'hDEADBEEF -> next cycle valid_o=1, ctrl_o=4'b0110, wR_o=5, data_o=32'hDEADBEEF.
REQ-040 Load 32'h1, then stall_i=1 for 3 cycles while data_i changes -> data_o stays 32'h1 for all 3 cycles, and stall_cnt_o=3.
REQ-041 stall_i=1 and flush_i=1 in the same cycle -> valid_o=0, ctrl_o=0, flush_cnt_o incremented by 1, stall_cnt_o unchanged.
REQ-042 valid_i=0 with ctrl_i=4'hF -> ctrl_o=0 and valid_o=0.
REQ-043 CNT_W=4 with stall_i=1 for 20 cycles -> stall_cnt_o=15 and held; then cnt_clr_i=1 together with stall_i=1 -> stall_cnt_o=0.
REQ-044 Assert rst_n=0 mid-cycle during a stall -> all outputs go to 0 before the next clock edge.
